mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
Memory-stage controller that produces the inputs and the enable for the MEM/WB latch. It consumes EX/MEM outputs and issues data-cache requests for LW/SW/LL/SC, holding the pipeline until dhit arrives. It keeps the per-core LL/SC link register, which coherence snoops invalidate. When it drives mw_enable low, the MEM/WB latch loads a bubble.

Parameters:
WORD_W, 32, data/address width
LINK_LSB, 2, lowest address bit compared for link match (word granularity)

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
ex_valid  in  1  EX/MEM holds a valid instruction
ex_opcode  in  6  opcode_t from EX/MEM
ex_alu_out  in  WORD_W  ALU result / effective address
ex_store  in  WORD_W  store data
ex_regw  in  1  register write enable
ex_regdest  in  5  destination register
ex_npc  in  WORD_W  next PC
ex_halt  in  1  halt marker
dhit  in  1  cache completed request
dmemload  in  WORD_W  cache read data
snoop_inv  in  1  coherence invalidate of snoop_addr
snoop_addr  in  WORD_W  invalidated address
dmemREN  out  1  cache read request
dmemWEN  out  1  cache write request
dmemaddr  out  WORD_W  request address
dmemstore  out  WORD_W  request write data
mem_stall  out  1  hold IF..EX/MEM
mw_enable  out  1  MEM/WB enable (0 = bubble)
mw_Mem, mw_Addr, mw_alu_out, mw_npc  out  WORD_W  MEM/WB data inputs
mw_RegW, mw_halt  out  1 each;  mw_RegDest  out  5;  mw_opcode  out  6

Behaviour:
- States: IDLE, REQ, HALTED. Reset puts the block in IDLE with link_valid=0, link_addr=0, the request registers at 0 and all outputs at 0. mw_opcode resets to RTYPE. Reset asserted mid-REQ drops dmemREN/dmemWEN immediately.
- mem op = ex_valid and opcode in {LW, SW, LL, SC}. SC_ok = link_valid and ex_alu_out[31:LINK_LSB] == link_addr[31:LINK_LSB].
- MEM/WB outputs are combinational; the MEM/WB block is the register. mw_Addr=dmemaddr in REQ, else ex_alu_out. The other mw_* fields pass through from ex_* whenever mw_enable=1, and are 0 otherwise.
- IDLE, non-mem valid op: mw_enable=1 and mw_Mem=0. No stall.
- IDLE, no valid op: mw_enable=0 and no stall.
- IDLE, LW/SW/LL, or SC with SC_ok: latch address and store data, then go to REQ. mem_stall=1 and mw_enable=0 this cycle.
- IDLE, SC with !SC_ok: no cache access. Complete in the same cycle with mw_enable=1, mw_Mem=0, mw_RegW=ex_regw.
- REQ: dmemREN=1 for LW/LL and dmemWEN=1 for SW/SC, driven from the latched registers. EX/MEM fields are stable because the stage is stalled. mem_stall = !dhit. On dhit:
  - mw_enable=1 for that single cycle.
  - mw_Mem=dmemload for LW/LL, 1 for SC, 0 for SW.
  - Go to IDLE; the next instruction is evaluated the following cycle.
- Minimum memory-op latency is 2 cycles (IDLE capture, REQ with same-cycle dhit). There is no upper bound.
- Link register:
  - LL completion sets link_valid=1 and link_addr=address.
  - SC completion (success) clears link_valid.
  - A SW completion whose address matches link_addr clears link_valid.
  - snoop_inv with a matching address clears link_valid in any state.
  - If snoop_inv matches in the same cycle an LL completes, the snoop wins and link_valid=0.
  - A snoop during an SC in REQ does not abort it; cache coherence guarantees atomicity.
- Halt: when mw_enable=1 with ex_halt=1, go to HALTED. In HALTED, mw_enable=0, mem_stall=1 and no requests are issued. Only reset exits HALTED.
- Only one outstanding request; dmemREN and dmemWEN are never asserted together.

Test Plan:
- Reset during REQ of LW 0x100: dmemREN falls asynchronously, all outputs are 0, mw_opcode=RTYPE, link_valid=0.
- ADDU, ex_alu_out=0x1234, regdest=3 -> same cycle: mw_enable=1, mw_alu_out=0x1234, mw_RegDest=3, mem_stall=0.
- LW 0x200 with dhit 3 cycles after REQ entry, dmemload=0xDEADBEEF:
  - mem_stall high for 4 cycles total.
  - Exactly one mw_enable pulse, with mw_Mem=0xDEADBEEF.
- LL 0x300, then SC 0x300 data 7 -> dmemWEN with dmemstore=7, mw_Mem=1, link cleared. A second SC to 0x300 -> no WEN, mw_Mem=0, completes with no stall.
- LL 0x300, then snoop_inv 0x304 -> link kept. Then snoop_inv 0x300 -> SC 0x300 fails with mw_Mem=0 and no cache access.
- HALT op -> one mw_enable with mw_halt=1. Afterwards mw_enable stays 0 and mem_stall stays 1 for 20 cycles, with no REN/WEN despite LW presented.

Source files
------------

// File: rtl/mem_stage_ctrl_if.sv
// Data-cache request bus between the memory stage (master) and the L1 data cache (slave).
interface mem_stage_ctrl_if #(
  parameter int WORD_W = 32
);
  logic              dmemREN;
  logic              dmemWEN;
  logic [WORD_W-1:0] dmemaddr;
  logic [WORD_W-1:0] dmemstore;
  logic              dhit;
  logic [WORD_W-1:0] dmemload;

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  dhit, dmemload
  );

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dhit, dmemload
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues data-cache requests for LW/SW/LL/SC, stalls until dhit,
// owns the LL/SC link register and produces the MEM/WB latch inputs and enable.
module mem_stage_ctrl #(
  parameter int WORD_W   = 32,
  parameter int LINK_LSB = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ex_valid,
  input  logic [5:0]        ex_opcode,
  input  logic [WORD_W-1:0] ex_alu_out,
  input  logic [WORD_W-1:0] ex_store,
  input  logic              ex_regw,
  input  logic [4:0]        ex_regdest,
  input  logic [WORD_W-1:0] ex_npc,
  input  logic              ex_halt,
  input  logic              snoop_inv,
  input  logic [WORD_W-1:0] snoop_addr,
  mem_stage_ctrl_if.master  dbus,
  output logic              mem_stall,
  output logic              mw_enable,
  output logic [WORD_W-1:0] mw_Mem,
  output logic [WORD_W-1:0] mw_Addr,
  output logic [WORD_W-1:0] mw_alu_out,
  output logic [WORD_W-1:0] mw_npc,
  output logic              mw_RegW,
  output logic              mw_halt,
  output logic [4:0]        mw_RegDest,
  output logic [5:0]        mw_opcode
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_LL    = 6'h30;
  localparam logic [5:0] OP_SC    = 6'h38;

  localparam logic [WORD_W-1:0] WORD_MASK = {WORD_W{1'b1}} << LINK_LSB;
  localparam logic [WORD_W-1:0] ONE_WORD  = {{(WORD_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, REQ, HALTED} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] store_q, store_d;
  logic [5:0]        op_q, op_d;
  logic              ren_q, ren_d;
  logic              wen_q, wen_d;
  logic              link_valid_q, link_valid_d;
  logic [WORD_W-1:0] link_addr_q, link_addr_d;

  logic              ex_rd, ex_wr, ex_sc, ex_mem, sc_ok;
  logic [WORD_W-1:0] mem_word;

  // Addresses are compared at word granularity; bits below LINK_LSB are masked off.
  function automatic logic same_word(input logic [WORD_W-1:0] a, input logic [WORD_W-1:0] b);
    return ((a ^ b) & WORD_MASK) == '0;
  endfunction

  assign ex_rd  = (ex_opcode == OP_LW) || (ex_opcode == OP_LL);
  assign ex_wr  = (ex_opcode == OP_SW) || (ex_opcode == OP_SC);
  assign ex_sc  = (ex_opcode == OP_SC);
  assign ex_mem = ex_valid && (ex_rd || ex_wr);
  assign sc_ok  = link_valid_q && same_word(ex_alu_out, link_addr_q);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    store_d      = store_q;
    op_d         = op_q;
    ren_d        = ren_q;
    wen_d        = wen_q;
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    mem_stall    = 1'b0;
    mw_enable    = 1'b0;
    mem_word     = '0;

    case (state_q)
      IDLE: begin
        if (ex_mem && !(ex_sc && !sc_ok)) begin
          mem_stall = 1'b1;
          state_d   = REQ;
          addr_d    = ex_alu_out;
          store_d   = ex_store;
          op_d      = ex_opcode;
          ren_d     = ex_rd;
          wen_d     = ex_wr;
        end else if (ex_valid) begin
          // Non-memory ops and failed SCs retire in this cycle without touching the cache.
          mw_enable = 1'b1;
        end
      end
      REQ: begin
        mem_stall = !dbus.dhit;
        if (dbus.dhit) begin
          mw_enable = 1'b1;
          ren_d     = 1'b0;
          wen_d     = 1'b0;
          state_d   = IDLE;
          if (ren_q)              mem_word = dbus.dmemload;
          else if (op_q == OP_SC) mem_word = ONE_WORD;
          if (op_q == OP_LL) begin
            link_valid_d = 1'b1;
            link_addr_d  = addr_q;
          end else if (op_q == OP_SC) begin
            link_valid_d = 1'b0;
          end else if (op_q == OP_SW && same_word(addr_q, link_addr_q)) begin
            link_valid_d = 1'b0;
          end
        end
      end
      HALTED: mem_stall = 1'b1;
      default: state_d = IDLE;
    endcase

    if (mw_enable && ex_halt) state_d = HALTED;

    // Compared against the post-update link so a snoop racing an LL completion wins.
    if (snoop_inv && same_word(snoop_addr, link_addr_d)) link_valid_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      store_q      <= '0;
      op_q         <= OP_RTYPE;
      ren_q        <= 1'b0;
      wen_q        <= 1'b0;
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      store_q      <= store_d;
      op_q         <= op_d;
      ren_q        <= ren_d;
      wen_q        <= wen_d;
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
    end
  end

  assign dbus.dmemREN   = ren_q;
  assign dbus.dmemWEN   = wen_q;
  assign dbus.dmemaddr  = addr_q;
  assign dbus.dmemstore = store_q;

  assign mw_Mem     = mem_word;
  assign mw_Addr    = (state_q == REQ) ? addr_q : ex_alu_out;
  assign mw_alu_out = mw_enable ? ex_alu_out : '0;
  assign mw_npc     = mw_enable ? ex_npc     : '0;
  assign mw_RegW    = mw_enable ? ex_regw    : 1'b0;
  assign mw_halt    = mw_enable ? ex_halt    : 1'b0;
  assign mw_RegDest = mw_enable ? ex_regdest : 5'd0;
  assign mw_opcode  = mw_enable ? ex_opcode  : OP_RTYPE;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: vector table, directed LL/SC/halt sequences and a
// randomized instruction stream checked against a transaction-level link/latency model.
module tb_mem_stage_ctrl;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_LL    = 6'h30;
  localparam logic [5:0] OP_SC    = 6'h38;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ex_valid = 1'b0;
  logic [5:0]  ex_opcode = '0;
  logic [31:0] ex_alu_out = '0, ex_store = '0, ex_npc = '0;
  logic        ex_regw = 1'b0, ex_halt = 1'b0;
  logic [4:0]  ex_regdest = '0;
  logic        snoop_inv = 1'b0;
  logic [31:0] snoop_addr = '0;
  logic        mem_stall, mw_enable, mw_RegW, mw_halt;
  logic [31:0] mw_Mem, mw_Addr, mw_alu_out, mw_npc;
  logic [4:0]  mw_RegDest;
  logic [5:0]  mw_opcode;

  mem_stage_ctrl_if #(.WORD_W(32)) dbus ();

  mem_stage_ctrl #(.WORD_W(32), .LINK_LSB(2)) dut (
    .CLK(CLK), .nRST(nRST),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_alu_out(ex_alu_out), .ex_store(ex_store),
    .ex_regw(ex_regw), .ex_regdest(ex_regdest), .ex_npc(ex_npc), .ex_halt(ex_halt),
    .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
    .dbus(dbus),
    .mem_stall(mem_stall), .mw_enable(mw_enable),
    .mw_Mem(mw_Mem), .mw_Addr(mw_Addr), .mw_alu_out(mw_alu_out), .mw_npc(mw_npc),
    .mw_RegW(mw_RegW), .mw_halt(mw_halt), .mw_RegDest(mw_RegDest), .mw_opcode(mw_opcode)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit wmatch(input logic [31:0] a, input logic [31:0] b);
    return (a >> 2) == (b >> 2);
  endfunction

  // Presents one instruction at posedge+1, plays the cache (dhit after 'delay' REQ cycles),
  // optionally pulses a snoop in REQ cycle 'snoop_k', and checks the retirement.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [31:0] addr,
                           input logic [31:0] st, input logic [31:0] ld, input logic rw,
                           input logic [4:0] rd, input logic [31:0] npc, input logic hlt,
                           input int delay, input int snoop_k, input logic [31:0] snoop_a,
                           input int exp_cycles, input logic [31:0] exp_mem,
                           input logic exp_rd, input logic exp_wr);
    int cyc = 0, rq = 0, stalls = 0, pulses = 0;
    logic saw_rd = 0, saw_wr = 0, both = 0, bad_addr = 0, bad_store = 0;
    logic [31:0] g_mem = '0, g_alu = '0, g_npc = '0, g_addr = '0;
    logic g_rw = 0, g_halt = 0;
    logic [4:0] g_rd = '0;
    logic [5:0] g_op = '0;
    bit done = 0;
    ex_valid = 1; ex_opcode = op; ex_alu_out = addr; ex_store = st; ex_regw = rw;
    ex_regdest = rd; ex_npc = npc; ex_halt = hlt; dbus.dmemload = ld; dbus.dhit = 0;
    while (!done && cyc < 40) begin
      @(negedge CLK);
      if (dbus.dmemREN || dbus.dmemWEN) begin
        if (rq == snoop_k) begin snoop_inv = 1; snoop_addr = snoop_a; end
        if (rq == delay) dbus.dhit = 1;
        saw_rd |= dbus.dmemREN;
        saw_wr |= dbus.dmemWEN;
        both   |= dbus.dmemREN & dbus.dmemWEN;
        if (dbus.dmemaddr !== addr) bad_addr = 1;
        if (dbus.dmemWEN && dbus.dmemstore !== st) bad_store = 1;
        rq++;
      end
      #1;
      if (mem_stall) stalls++;
      if (mw_enable) begin
        pulses++; done = 1;
        g_mem = mw_Mem; g_alu = mw_alu_out; g_npc = mw_npc; g_addr = mw_Addr;
        g_rw = mw_RegW; g_halt = mw_halt; g_rd = mw_RegDest; g_op = mw_opcode;
      end
      @(posedge CLK); #1;
      dbus.dhit = 0; snoop_inv = 0; cyc++;
    end
    ex_valid = 0; ex_halt = 0;
    chk({tag, ".cycles"}, cyc, exp_cycles);
    chk({tag, ".pulses"}, pulses, 1);
    chk({tag, ".stalls"}, stalls, exp_cycles - 1);
    chk({tag, ".mw_Mem"}, g_mem, exp_mem);
    chk({tag, ".fields"}, {g_rw, g_halt, g_rd, g_op}, {rw, hlt, rd, op});
    chk({tag, ".alu_npc"}, {g_alu, g_npc}, {addr, npc});
    chk({tag, ".mw_Addr"}, g_addr, addr);
    chk({tag, ".access"}, {saw_rd, saw_wr, both}, {exp_rd, exp_wr, 1'b0});
    chk({tag, ".bus"}, {bad_addr, bad_store}, 2'b00);
  endtask

  task automatic idle_snoop(input logic [31:0] a);
    snoop_inv = 1; snoop_addr = a;
    @(posedge CLK); #1;
    snoop_inv = 0;
  endtask

  typedef struct {
    logic        v;
    logic [5:0]  op;
    logic [31:0] alu;
    logic        regw;
    logic [4:0]  rd;
    logic [31:0] npc;
    logic        exp_en;
    logic        exp_stall;
  } vec_t;

  vec_t        vt [0:7];
  logic [5:0]  rops [0:6];
  logic [31:0] bases [0:3];
  logic [5:0]  op;
  logic [31:0] addr, st, ld, sa, e_mem;
  int          delay, k, e_cyc;
  logic        e_rd, e_wr, m_v;
  logic [31:0] m_a;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b1, OP_RTYPE, 32'h1234, 1'b1, 5'd3,  32'h44, 1'b1, 1'b0};
    vt[1] = '{1'b0, OP_RTYPE, 32'h5555, 1'b1, 5'd7,  32'h48, 1'b0, 1'b0};
    vt[2] = '{1'b1, OP_LW,    32'h200,  1'b1, 5'd4,  32'h4C, 1'b0, 1'b1};
    vt[3] = '{1'b1, OP_SW,    32'h204,  1'b0, 5'd0,  32'h50, 1'b0, 1'b1};
    vt[4] = '{1'b1, OP_LL,    32'h208,  1'b1, 5'd5,  32'h54, 1'b0, 1'b1};
    vt[5] = '{1'b1, OP_SC,    32'h100,  1'b1, 5'd6,  32'h58, 1'b1, 1'b0};
    vt[6] = '{1'b1, OP_BEQ,   32'h0,    1'b0, 5'd0,  32'h5C, 1'b1, 1'b0};
    vt[7] = '{1'b0, OP_LW,    32'h300,  1'b1, 5'd9,  32'h60, 1'b0, 1'b0};
    rops  = '{OP_RTYPE, OP_LW, OP_SW, OP_LL, OP_SC, OP_LL, OP_SC};
    bases = '{32'h300, 32'h304, 32'h308, 32'h400};
    dbus.dhit = 0; dbus.dmemload = '0;

    repeat (2) @(posedge CLK);
    #1 nRST = 1;
    @(posedge CLK); #1;

    // Set a link, then reset in the middle of an LW request.
    run_instr("ll0", OP_LL, 32'h100, 0, 32'h11, 1, 2, 32'h10, 0, 0, -1, 0, 2, 32'h11, 1, 0);
    ex_valid = 1; ex_opcode = OP_LW; ex_alu_out = 32'h100; ex_regw = 1; ex_regdest = 8;
    @(posedge CLK); #1;
    chk("rst.ren_before", dbus.dmemREN, 1);
    #2 nRST = 0;
    #1;
    chk("rst.ren_wen_async", {dbus.dmemREN, dbus.dmemWEN}, 2'b00);
    ex_valid = 0; ex_opcode = '0; ex_alu_out = '0; ex_store = '0; ex_regw = 0;
    ex_regdest = '0; ex_npc = '0; ex_halt = 0;
    #1;
    chk("rst.ctrl", {mem_stall, mw_enable, mw_RegW, mw_halt}, 4'b0000);
    chk("rst.bus", {dbus.dmemaddr, dbus.dmemstore}, 64'h0);
    chk("rst.mw_data", {mw_Mem, mw_Addr, mw_alu_out, mw_npc, 3'b0, mw_RegDest}, 136'h0);
    chk("rst.mw_opcode", mw_opcode, OP_RTYPE);
    @(posedge CLK); #1 nRST = 1;

    // Single-cycle IDLE behaviour; inputs withdrawn before the edge so the state stays IDLE.
    for (int i = 0; i < 8; i++) begin
      ex_valid = vt[i].v; ex_opcode = vt[i].op; ex_alu_out = vt[i].alu; ex_regw = vt[i].regw;
      ex_regdest = vt[i].rd; ex_npc = vt[i].npc; ex_store = 32'hA5A5_0000 + i;
      #2;
      chk($sformatf("vec%0d.en_stall", i), {mw_enable, mem_stall}, {vt[i].exp_en, vt[i].exp_stall});
      chk($sformatf("vec%0d.alu", i), mw_alu_out, vt[i].exp_en ? vt[i].alu : 32'h0);
      chk($sformatf("vec%0d.npc", i), mw_npc, vt[i].exp_en ? vt[i].npc : 32'h0);
      chk($sformatf("vec%0d.rd_rw", i), {mw_RegDest, mw_RegW},
          vt[i].exp_en ? {vt[i].rd, vt[i].regw} : 6'h0);
      chk($sformatf("vec%0d.op", i), mw_opcode, vt[i].exp_en ? vt[i].op : OP_RTYPE);
      chk($sformatf("vec%0d.mem_addr", i), {mw_Mem, mw_Addr}, {32'h0, vt[i].alu});
      chk($sformatf("vec%0d.noreq", i), {dbus.dmemREN, dbus.dmemWEN}, 2'b00);
      #1 ex_valid = 0;
      @(posedge CLK); #1;
    end

    run_instr("lw", OP_LW, 32'h200, 0, 32'hDEADBEEF, 1, 2, 32'h64, 0, 3, -1, 0, 5, 32'hDEADBEEF, 1, 0);
    #3 chk("lw.after", {mw_enable, mem_stall}, 2'b00);
    @(posedge CLK); #1;

    run_instr("ll1", OP_LL, 32'h300, 0, 32'hAAAA, 1, 3, 32'h68, 0, 1, -1, 0, 3, 32'hAAAA, 1, 0);
    run_instr("sc1", OP_SC, 32'h300, 7, 0, 1, 3, 32'h6C, 0, 0, -1, 0, 2, 32'h1, 0, 1);
    run_instr("sc2", OP_SC, 32'h300, 9, 0, 1, 3, 32'h70, 0, 0, -1, 0, 1, 32'h0, 0, 0);

    run_instr("ll2", OP_LL, 32'h300, 0, 32'h5, 1, 3, 32'h74, 0, 0, -1, 0, 2, 32'h5, 1, 0);
    idle_snoop(32'h304);
    run_instr("sc_kept", OP_SC, 32'h300, 8, 0, 1, 3, 32'h78, 0, 1, -1, 0, 3, 32'h1, 0, 1);
    run_instr("ll3", OP_LL, 32'h300, 0, 32'h6, 1, 3, 32'h7C, 0, 0, -1, 0, 2, 32'h6, 1, 0);
    idle_snoop(32'h300);
    run_instr("sc_snooped", OP_SC, 32'h300, 8, 0, 1, 3, 32'h80, 0, 0, -1, 0, 1, 32'h0, 0, 0);

    // Snoop in the very cycle the LL completes: the snoop wins.
    run_instr("ll_race", OP_LL, 32'h300, 0, 32'h7, 1, 3, 32'h84, 0, 2, 2, 32'h302, 4, 32'h7, 1, 0);
    run_instr("sc_race", OP_SC, 32'h300, 8, 0, 1, 3, 32'h88, 0, 0, -1, 0, 1, 32'h0, 0, 0);
    // Snoop during an SC request does not abort it.
    run_instr("ll4", OP_LL, 32'h300, 0, 32'h8, 1, 3, 32'h8C, 0, 0, -1, 0, 2, 32'h8, 1, 0);
    run_instr("sc_inreq", OP_SC, 32'h300, 3, 0, 1, 3, 32'h90, 0, 2, 0, 32'h300, 4, 32'h1, 0, 1);
    // A store to the linked word breaks the link.
    run_instr("ll5", OP_LL, 32'h308, 0, 32'h9, 1, 3, 32'h94, 0, 0, -1, 0, 2, 32'h9, 1, 0);
    run_instr("sw_brk", OP_SW, 32'h30B, 4, 0, 0, 0, 32'h98, 0, 1, -1, 0, 3, 32'h0, 0, 1);
    run_instr("sc_brk", OP_SC, 32'h308, 4, 0, 1, 3, 32'h9C, 0, 0, -1, 0, 1, 32'h0, 0, 0);

    m_v = 0; m_a = '0;
    for (int i = 0; i < 80; i++) begin
      op = rops[$urandom_range(0, 6)];
      addr = bases[$urandom_range(0, 3)] + $urandom_range(0, 3);
      st = $urandom; ld = $urandom;
      delay = $urandom_range(0, 3);
      k = -1;
      if ($urandom_range(0, 2) == 0) k = $urandom_range(0, delay);
      sa = bases[$urandom_range(0, 3)] + $urandom_range(0, 3);
      e_rd = 0; e_wr = 0; e_mem = 0; e_cyc = delay + 2;
      case (op)
        OP_LW: begin
          e_rd = 1; e_mem = ld;
          if (k >= 0 && wmatch(sa, m_a)) m_v = 0;
        end
        OP_LL: begin
          e_rd = 1; e_mem = ld;
          m_v = 1; m_a = addr;
          if (k == delay && wmatch(sa, addr)) m_v = 0;
        end
        OP_SW: begin
          e_wr = 1;
          if (wmatch(addr, m_a) || (k >= 0 && wmatch(sa, m_a))) m_v = 0;
        end
        OP_SC: begin
          if (m_v && wmatch(addr, m_a)) begin
            e_wr = 1; e_mem = 1; m_v = 0;
          end else begin
            e_cyc = 1; k = -1;
          end
        end
        default: begin e_cyc = 1; k = -1; end
      endcase
      run_instr($sformatf("rnd%0d", i), op, addr, st, ld, 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 31)), $urandom, 0, delay, k, sa, e_cyc, e_mem, e_rd, e_wr);
      if ($urandom_range(0, 3) == 0) begin
        sa = bases[$urandom_range(0, 3)] + $urandom_range(0, 3);
        idle_snoop(sa);
        if (wmatch(sa, m_a)) m_v = 0;
      end
    end

    run_instr("halt", OP_HALT, 32'h0, 0, 0, 0, 0, 32'hA0, 1, 0, -1, 0, 1, 32'h0, 0, 0);
    ex_valid = 1; ex_opcode = OP_LW; ex_alu_out = 32'h200; ex_regw = 1; ex_regdest = 2;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      dbus.dhit = 1;
      #1;
      chk($sformatf("halted%0d", i), {mw_enable, mem_stall, dbus.dmemREN, dbus.dmemWEN}, 4'b0100);
    end
    dbus.dhit = 0; ex_valid = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
